lcd_nibble_reader: RTL and testbench

Read-side companion to the LCD 4-bit instruction writer. On request it performs one LCD read cycle over the 4-bit bus (RW=1), either a busy-flag/address read (RS=0) or a data read (RS=1). It strobes LCD_E twice, upper nibble first, and assembles the returned byte for the control FSM. It sits beside the writer under the LCD controller top level; the top level muxes LCD_RS/LCD_RW/LCD_E from whichever block has `rd_active`, and tristates the FPGA SF_D drivers while `rd_active`=1.

---
 rtl/lcd_nibble_reader_if.sv | 33 +++
 rtl/lcd_nibble_reader.sv | 211 +++++++++++++++++++++
 tb/tb_lcd_nibble_reader.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_nibble_reader_if.sv
// ---------------------------------------------------------------------------
// lcd_nibble_reader_if
// Request/response bundle between the LCD control FSM (master) and the
// 4-bit LCD read engine (slave).
//   start     master->slave  request one read (taken only while ready=1)
//   rs_sel    master->slave  0 = busy flag/address read, 1 = data read
//   ready     slave->master  reader idle, start will be accepted
//   data      slave->master  assembled byte {upper nibble, lower nibble}
//   busy_flag slave->master  data[7] for busy/address reads, else 0
//   addr      slave->master  data[6:0] for busy/address reads, else 0
//   done      slave->master  one-cycle pulse, results valid from here on
//   timeout   slave->master  busy-poll limit reached (poll build only)
// ---------------------------------------------------------------------------
interface lcd_nibble_reader_if;
  logic       start;
  logic       rs_sel;
  logic       ready;
  logic [7:0] data;
  logic       busy_flag;
  logic [6:0] addr;
  logic       done;
  logic       timeout;

  modport master (
    output start, rs_sel,
    input  ready, data, busy_flag, addr, done, timeout
  );

  modport slave (
    input  start, rs_sel,
    output ready, data, busy_flag, addr, done, timeout
  );
endinterface

// File: rtl/lcd_nibble_reader.sv
// ---------------------------------------------------------------------------
// lcd_nibble_reader
// Performs one LCD read cycle over the 4-bit bus (RW=1): E is strobed twice,
// upper nibble first, and the returned byte is assembled for the control FSM.
// The LCD top level muxes RS/RW/E from whichever block has rd_active and
// tristates the FPGA SF_D drivers while rd_active=1.
//
// Ports
//   clk        system clock (50 MHz)
//   reset      asynchronous, active-low reset
//   bus        lcd_nibble_reader_if.slave (start/rs_sel in, results out)
//   SF_D_in    LCD data bus DB7..DB4 as seen by the FPGA
//   LCD_RS     register select (latched rs_sel during the read)
//   LCD_RW     1 while the reader owns the bus
//   LCD_E      enable strobe
//   rd_active  reader owns the LCD bus
//
// Build option
//   LCD_READ_BUSY_POLL_EN: a busy-flag read that returns BF=1 is repeated
//   (after a gap) until BF=0 or POLL_MAX reads have been made; the last
//   case reports timeout=1. Undefined: one read per start, timeout=0.
//
// All LCD pins are registered from the next state so they change cleanly on
// the clock edge and drop asynchronously with reset.
// ---------------------------------------------------------------------------
module lcd_nibble_reader #(
  parameter int SETUP_CYC  = 2,
  parameter int E_HIGH_CYC = 12,
  parameter int HOLD_CYC   = 1,
  parameter int GAP_CYC    = 50,
  parameter int POLL_MAX   = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  lcd_nibble_reader_if.slave   bus,
  input  logic [3:0]           SF_D_in,
  output logic                 LCD_RS,
  output logic                 LCD_RW,
  output logic                 LCD_E,
  output logic                 rd_active
);

  // Every phase length is loaded as (length-1) into a 12-bit counter.
  if (SETUP_CYC < 1 || E_HIGH_CYC < 1 || HOLD_CYC < 1 || GAP_CYC < 1 ||
      SETUP_CYC > 4096 || E_HIGH_CYC > 4096 || HOLD_CYC > 4096 ||
      GAP_CYC > 4096 || POLL_MAX < 1) begin : g_param_check
    $error("lcd_nibble_reader: phase lengths must be 1..4096, POLL_MAX >= 1");
  end

  typedef enum logic [3:0] {
    IDLE, SETUP_H, EHI_H, HOLD_H, GAP, SETUP_L, EHI_L, HOLD_L, DONE
  } state_t;

  state_t      state, state_nxt;
  logic [11:0] cnt;
  logic        load;
  logic        last;
  logic        enter_done;
  logic        poll_again;
  logic        rearm;
  logic        own_nxt;
  logic        rs_cur;
  logic        rs_lat;
  logic [3:0]  nib_hi, nib_lo;
  logic [7:0]  data_q;
  logic        bf_q;
  logic [6:0]  addr_q;
  logic        done_q;
  logic        ready_q;

  function automatic logic [11:0] phase_len(input state_t s);
    case (s)
      SETUP_H, SETUP_L: phase_len = 12'(SETUP_CYC - 1);
      EHI_H, EHI_L:     phase_len = 12'(E_HIGH_CYC - 1);
      HOLD_H, HOLD_L:   phase_len = 12'(HOLD_CYC - 1);
      GAP:              phase_len = 12'(GAP_CYC - 1);
      default:          phase_len = 12'd0;
    endcase
  endfunction

  assign last       = (cnt == 12'd0);
  assign enter_done = (state == HOLD_L) && last && !poll_again;
  // rs_sel is only sampled on the accepting edge; afterwards the latch rules.
  assign rs_cur     = (state == IDLE) ? bus.rs_sel : rs_lat;
  assign own_nxt    = (state_nxt != IDLE) && (state_nxt != DONE);

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      IDLE:    if (bus.start) begin state_nxt = SETUP_H; load = 1'b1; end
      SETUP_H: if (last) begin state_nxt = EHI_H;  load = 1'b1; end
      EHI_H:   if (last) begin state_nxt = HOLD_H; load = 1'b1; end
      HOLD_H:  if (last) begin state_nxt = GAP;    load = 1'b1; end
      GAP:     if (last) begin
                 state_nxt = rearm ? SETUP_H : SETUP_L;
                 load      = 1'b1;
               end
      SETUP_L: if (last) begin state_nxt = EHI_L;  load = 1'b1; end
      EHI_L:   if (last) begin state_nxt = HOLD_L; load = 1'b1; end
      HOLD_L:  if (last) begin
                 state_nxt = poll_again ? GAP : DONE;
                 load      = 1'b1;
               end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= 12'd0;
    end else begin
      state <= state_nxt;
      if (load)
        cnt <= phase_len(state_nxt);
      else if (!last)
        cnt <= cnt - 12'd1;
    end
  end

  // Bus capture: each nibble is taken on the edge where E falls.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rs_lat <= 1'b0;
      nib_hi <= 4'h0;
      nib_lo <= 4'h0;
      data_q <= 8'h00;
      bf_q   <= 1'b0;
      addr_q <= 7'h00;
    end else begin
      if (state == IDLE && bus.start)
        rs_lat <= bus.rs_sel;
      if (state == EHI_H && last)
        nib_hi <= SF_D_in;
      if (state == EHI_L && last)
        nib_lo <= SF_D_in;
      if (enter_done) begin
        data_q <= {nib_hi, nib_lo};
        bf_q   <= !rs_lat && nib_hi[3];
        addr_q <= rs_lat ? 7'h00 : {nib_hi[2:0], nib_lo};
      end
    end
  end

  // Pins and handshake flags registered from the next state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      LCD_RS    <= 1'b0;
      LCD_RW    <= 1'b0;
      LCD_E     <= 1'b0;
      rd_active <= 1'b0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      LCD_RS    <= own_nxt && rs_cur;
      LCD_RW    <= own_nxt;
      LCD_E     <= (state_nxt == EHI_H) || (state_nxt == EHI_L);
      rd_active <= own_nxt;
      ready_q   <= (state_nxt == IDLE);
      done_q    <= (state_nxt == DONE);
    end
  end

`ifdef LCD_READ_BUSY_POLL_EN
  localparam int PW = (POLL_MAX > 1) ? $clog2(POLL_MAX) : 1;

  logic [PW-1:0] poll_cnt;   // reads already completed in this request
  logic          rearm_q;
  logic          timeout_q;

  assign poll_again = !rs_lat && nib_hi[3] && (poll_cnt < PW'(POLL_MAX - 1));
  assign rearm      = rearm_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      poll_cnt  <= '0;
      rearm_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      if (state == IDLE && bus.start) begin
        poll_cnt  <= '0;
        timeout_q <= 1'b0;
      end
      if (state == HOLD_L && last && poll_again) begin
        poll_cnt <= poll_cnt + 1'b1;
        rearm_q  <= 1'b1;
      end
      if (state == GAP && last)
        rearm_q <= 1'b0;
      // Reaching DONE with BF still set means the poll limit ran out.
      if (enter_done)
        timeout_q <= !rs_lat && nib_hi[3];
    end
  end

  assign bus.timeout = timeout_q;
`else
  assign poll_again  = 1'b0;
  assign rearm       = 1'b0;
  assign bus.timeout = 1'b0;
`endif

  assign bus.ready     = ready_q;
  assign bus.done      = done_q;
  assign bus.data      = data_q;
  assign bus.busy_flag = bf_q;
  assign bus.addr      = addr_q;

endmodule

// File: tb/tb_lcd_nibble_reader.sv
// ---------------------------------------------------------------------------
// tb_lcd_nibble_reader
// Bench for lcd_nibble_reader: directed timing sequences, a table of read
// vectors, reset-abort sequences and randomized reads against a read-level
// model. The LCD side returns valid nibbles only late in each E-high window.
// ---------------------------------------------------------------------------
module tb_lcd_nibble_reader;

  localparam int S = 2;
  localparam int E = 12;
  localparam int H = 1;
  localparam int G = 50;
`ifdef LCD_READ_BUSY_POLL_EN
  localparam int PMAX    = 4;
  localparam bit POLL_EN = 1'b1;
`else
  localparam int PMAX    = 255;
  localparam bit POLL_EN = 1'b0;
`endif
  localparam int READ_CYC = 2 * (S + E + H) + G;  // bus-owned cycles per read

  logic       clk;
  logic       reset;
  logic [3:0] SF_D_in;
  logic       LCD_RS, LCD_RW, LCD_E, rd_active;

  lcd_nibble_reader_if bus ();

  lcd_nibble_reader #(
    .SETUP_CYC (S),
    .E_HIGH_CYC(E),
    .HOLD_CYC  (H),
    .GAP_CYC   (G),
    .POLL_MAX  (PMAX)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus.slave),
    .SF_D_in  (SF_D_in),
    .LCD_RS   (LCD_RS),
    .LCD_RW   (LCD_RW),
    .LCD_E    (LCD_E),
    .rd_active(rd_active)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Per-read values the LCD returns (index = read number within a request).
  logic [3:0] hi_seq [16];
  logic [3:0] lo_seq [16];

  // Observations from the last run_read.
  int         done_cyc[$];
  int         rise_cyc[$];
  int         fall_cyc[$];
  int         rd_bad, rd_cycles, ready_busy;
  logic [7:0] got_data;
  logic       got_bf, got_to, to_c1;
  logic [6:0] got_addr;

  typedef struct {
    bit         rs;
    logic [3:0] hi;
    logic [3:0] lo;
    logic [7:0] data;
    bit         bf;
    logic [6:0] addr;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Number of reads a request makes, from the polling rule.
  function automatic int model_reads(input bit rs);
    int k;
    k = 1;
    if (POLL_EN && !rs)
      while (hi_seq[k-1][3] && k < PMAX && k < 16) k++;
    return k;
  endfunction

  // Issue start (sampled at edge 0) and observe cycles 1..max_cyc at negedges.
  task automatic run_read(input bit rs, input int hold_start, input int n_done, input int max_cyc);
    int pulse, ehi, idx;
    bit prev_e;
    pulse = 0; ehi = 0; prev_e = 1'b0;
    done_cyc.delete(); rise_cyc.delete(); fall_cyc.delete();
    rd_bad = 0; rd_cycles = 0; ready_busy = 0; to_c1 = 1'bx;
    @(negedge clk);
    bus.start  = 1'b1;
    bus.rs_sel = rs;
    for (int cyc = 1; cyc <= max_cyc; cyc++) begin
      @(negedge clk);
      if (cyc > hold_start) begin
        bus.start  = 1'b0;
        bus.rs_sel = 1'($urandom);  // must have been latched already
      end
      if (cyc == 1) to_c1 = bus.timeout;
      if (LCD_E && !prev_e) begin pulse++; ehi = 0; rise_cyc.push_back(cyc); end
      if (!LCD_E && prev_e) fall_cyc.push_back(cyc);
      prev_e = LCD_E;
      if (LCD_E) ehi++;
      if (rd_active) begin
        rd_cycles++;
        if (LCD_RS !== rs || LCD_RW !== 1'b1) rd_bad++;
      end
      if (bus.ready && (rd_active || bus.done)) ready_busy++;
      if (bus.done) begin
        done_cyc.push_back(cyc);
        got_data = bus.data; got_bf = bus.busy_flag;
        got_addr = bus.addr; got_to = bus.timeout;
      end
      idx = (pulse > 0) ? (pulse - 1) / 2 : 0;
      if (idx > 15) idx = 15;
      // LCD output is valid ~160 ns into E high; earlier it is junk.
      if (LCD_E && ehi >= 9)
        SF_D_in = (pulse % 2 == 1) ? hi_seq[idx] : lo_seq[idx];
      else
        SF_D_in = 4'($urandom);
      if (done_cyc.size() >= n_done) break;
    end
  endtask

  task automatic check_model(input string tag, input bit rs);
    int k;
    logic [3:0] eh, el;
    k  = model_reads(rs);
    eh = hi_seq[k-1];
    el = lo_seq[k-1];
    check({tag, " done count"}, done_cyc.size(), 1);
    check({tag, " done cycle"}, (done_cyc.size() > 0) ? done_cyc[0] : -1,
          k * READ_CYC + (k - 1) * G + 1);
    check({tag, " data"}, got_data, {eh, el});
    check({tag, " busy_flag"}, got_bf, !rs && eh[3]);
    check({tag, " addr"}, got_addr, rs ? 7'h00 : {eh[2:0], el});
    check({tag, " timeout"}, got_to, POLL_EN && !rs && eh[3]);
    check({tag, " E pulses"}, rise_cyc.size(), 2 * k);
    check({tag, " rd_active cycles"}, rd_cycles, k * READ_CYC + (k - 1) * G);
    check({tag, " RS/RW while active"}, rd_bad, 0);
    check({tag, " ready while busy"}, ready_busy, 0);
  endtask

  initial begin : watchdog
    #4_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int rp[2];
    reset = 1'b0; bus.start = 1'b0; bus.rs_sel = 1'b0; SF_D_in = 4'h0;
    repeat (3) @(negedge clk);

    // Reset state
    check("reset LCD_E", LCD_E, 0);
    check("reset LCD_RW", LCD_RW, 0);
    check("reset LCD_RS", LCD_RS, 0);
    check("reset rd_active", rd_active, 0);
    check("reset ready", bus.ready, 1);
    check("reset done", bus.done, 0);
    check("reset data", bus.data, 0);
    check("reset busy_flag", bus.busy_flag, 0);
    check("reset addr", bus.addr, 0);
    check("reset timeout", bus.timeout, 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Data read A5 with full pin timing
    for (int i = 0; i < 16; i++) begin hi_seq[i] = 4'hA; lo_seq[i] = 4'h5; end
    run_read(1'b1, 0, 1, 300);
    check("A5 done count", done_cyc.size(), 1);
    check("A5 done cycle", (done_cyc.size() > 0) ? done_cyc[0] : -1, 81);
    check("A5 data", got_data, 8'hA5);
    check("A5 busy_flag", got_bf, 0);
    check("A5 addr", got_addr, 7'h00);
    check("A5 E rises", rise_cyc.size(), 2);
    check("A5 E1 rise cycle", (rise_cyc.size() > 0) ? rise_cyc[0] : -1, 3);
    check("A5 E1 width", (fall_cyc.size() > 0) ? fall_cyc[0] - rise_cyc[0] : -1, 12);
    check("A5 E low between nibbles (hold+gap+setup)",
          (rise_cyc.size() > 1) ? rise_cyc[1] - fall_cyc[0] : -1, 53);
    check("A5 E2 rise cycle", (rise_cyc.size() > 1) ? rise_cyc[1] : -1, 68);
    check("A5 E2 width", (fall_cyc.size() > 1) ? fall_cyc[1] - rise_cyc[1] : -1, 12);
    check("A5 RS/RW while active", rd_bad, 0);
    check("A5 rd_active cycles", rd_cycles, 80);
    @(negedge clk);
    check("A5 ready at cycle 82", bus.ready, 1);
    check("A5 done single pulse", bus.done, 0);
    check("A5 RW low after read", LCD_RW, 0);

    // Busy/address read 83
    for (int i = 0; i < 16; i++) begin hi_seq[i] = 4'h8; lo_seq[i] = 4'h3; end
    run_read(1'b0, 0, 1, 1000);
    check("BF data", got_data, 8'h83);
    check("BF busy_flag", got_bf, 1);
    check("BF addr", got_addr, 7'h03);
    check("BF RS=0 while active", rd_bad, 0);
    check_model("BF model", 1'b0);

    // start held high: second read only after ready returns
    hi_seq[0] = 4'h3; lo_seq[0] = 4'h9; hi_seq[1] = 4'hC; lo_seq[1] = 4'h6;
    run_read(1'b1, 82, 2, 400);
    check("held done count", done_cyc.size(), 2);
    check("held first done", (done_cyc.size() > 0) ? done_cyc[0] : -1, 81);
    check("held second done", (done_cyc.size() > 1) ? done_cyc[1] : -1, 163);
    check("held second start E rise", (rise_cyc.size() > 2) ? rise_cyc[2] : -1, 85);
    check("held second data", got_data, 8'hC6);
    check("held ready while busy", ready_busy, 0);

    // Reset mid-read: during EHI_H (cycle 10) and during GAP (cycle 40)
    rp[0] = 10; rp[1] = 40;
    foreach (rp[r]) begin
      int dn;
      @(negedge clk);
      bus.start = 1'b1; bus.rs_sel = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (rp[r] - 1) @(negedge clk);
      check($sformatf("rst@%0d rd_active before", rp[r]), rd_active, 1);
      check($sformatf("rst@%0d LCD_E before", rp[r]), LCD_E, (rp[r] == 10) ? 1 : 0);
      #2 reset = 1'b0;
      #1;
      check($sformatf("rst@%0d LCD_E", rp[r]), LCD_E, 0);
      check($sformatf("rst@%0d LCD_RW", rp[r]), LCD_RW, 0);
      check($sformatf("rst@%0d rd_active", rp[r]), rd_active, 0);
      check($sformatf("rst@%0d data", rp[r]), bus.data, 0);
      check($sformatf("rst@%0d ready", rp[r]), bus.ready, 1);
      @(negedge clk);
      reset = 1'b1;
      dn = 0;
      for (int c = 0; c < 150; c++) begin
        @(negedge clk);
        if (bus.done || rd_active) dn++;
      end
      check($sformatf("rst@%0d no done/no restart", rp[r]), dn, 0);
      check($sformatf("rst@%0d data after", rp[r]), bus.data, 0);
    end

    // Table of read vectors
    vecs[0] = '{1'b1, 4'hA, 4'h5, 8'hA5, 1'b0, 7'h00};
    vecs[1] = '{1'b0, 4'h8, 4'h3, 8'h83, 1'b1, 7'h03};
    vecs[2] = '{1'b0, 4'h0, 4'h0, 8'h00, 1'b0, 7'h00};
    vecs[3] = '{1'b1, 4'hF, 4'hF, 8'hFF, 1'b0, 7'h00};
    vecs[4] = '{1'b0, 4'h7, 4'hF, 8'h7F, 1'b0, 7'h7F};
    vecs[5] = '{1'b0, 4'hF, 4'h0, 8'hF0, 1'b1, 7'h70};
    foreach (vecs[v]) begin
      for (int i = 0; i < 16; i++) begin hi_seq[i] = vecs[v].hi; lo_seq[i] = vecs[v].lo; end
      run_read(vecs[v].rs, 0, 1, 1000);
      check($sformatf("vec%0d data", v), got_data, vecs[v].data);
      check($sformatf("vec%0d busy_flag", v), got_bf, vecs[v].bf);
      check($sformatf("vec%0d addr", v), got_addr, vecs[v].addr);
      check($sformatf("vec%0d done count", v), done_cyc.size(), 1);
    end

    // Randomized back-to-back reads against the model
    for (int t = 0; t < 24; t++) begin
      bit rs;
      rs = 1'($urandom);
      for (int i = 0; i < 16; i++) begin
        hi_seq[i] = 4'($urandom);
        lo_seq[i] = 4'($urandom);
      end
      run_read(rs, 0, 1, 1000);
      check_model($sformatf("rand%0d", t), rs);
    end

`ifdef LCD_READ_BUSY_POLL_EN
    // BF=1 for three reads, then BF=0
    for (int i = 0; i < 16; i++) begin hi_seq[i] = 4'h8; lo_seq[i] = 4'($urandom); end
    hi_seq[3] = 4'h2;
    run_read(1'b0, 0, 1, 1000);
    check("poll upper-nibble pulses", rise_cyc.size() / 2, 4);
    check("poll done count", done_cyc.size(), 1);
    check("poll busy_flag", got_bf, 0);
    check("poll timeout", got_to, 0);
    check_model("poll model", 1'b0);

    // BF stuck at 1: limit reached
    for (int i = 0; i < 16; i++) hi_seq[i] = 4'h9;
    run_read(1'b0, 0, 1, 1000);
    check("stuck done cycle", (done_cyc.size() > 0) ? done_cyc[0] : -1,
          4 * READ_CYC + 3 * G + 1);
    check("stuck timeout", got_to, 1);
    check("stuck busy_flag", got_bf, 1);

    // timeout clears on the next start
    run_read(1'b1, 0, 1, 1000);
    check("timeout cleared by start", to_c1, 0);
    check("timeout after data read", got_to, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
